// File: rtl/frogger_game_fsm_if.sv
// Interface bundling the game-flow controller's tick, control, collision,
// speed and status signals. The testbench/top level drives through the
// master modport and the controller connects through the slave modport.
interface frogger_game_fsm_if #(
   parameter int NUM_LANES = 11
);
   logic                   clk_enable;
   logic                   start;
   logic                   death_collision;
   logic                   win_collision;
   logic [NUM_LANES*4-1:0] lane_base_speed;
   logic [NUM_LANES*4-1:0] lane_speed;
   logic [3:0]             level;
   logic [2:0]             lives;
   logic [7:0]             score_bcd;
   logic                   round_reset;
   logic                   game_over;
   logic [2:0]             state;

   modport master (
      output clk_enable, start, death_collision, win_collision, lane_base_speed,
      input  lane_speed, level, lives, score_bcd, round_reset, game_over, state
   );

   modport slave (
      input  clk_enable, start, death_collision, win_collision, lane_base_speed,
      output lane_speed, level, lives, score_bcd, round_reset, game_over, state
   );
endinterface

// File: rtl/frogger_game_fsm.sv
// Frogger game-flow controller: tracks lives, level and a BCD win count,
// inserts timed pauses after deaths and wins, and derives per-lane car
// speeds from the base-speed vector and the current level.
module frogger_game_fsm #(
   parameter int NUM_LANES   = 11,
   parameter int MAX_LEVEL   = 8,
   parameter int START_LIVES = 3,
   parameter int PAUSE_TICKS = 50
) (
   input logic               clk,
   input logic               reset,
   frogger_game_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PLAY      = 3'd1,
      DYING     = 3'd2,
      LEVEL_UP  = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   localparam int              CNT_W         = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
   localparam logic [CNT_W-1:0] PAUSE_LAST   = CNT_W'(PAUSE_TICKS - 1);
   localparam logic [3:0]      MAX_LEVEL_L   = 4'(MAX_LEVEL);
   localparam logic [2:0]      START_LIVES_L = 3'(START_LIVES);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       pause_cnt;
   logic [3:0]             level_q;
   logic [2:0]             lives_q;
   logic [7:0]             score_q;
   logic                   round_reset_q;
   logic                   game_over_q;
   logic [NUM_LANES*4-1:0] lane_speed_q, lane_speed_d;
   logic                   pause_done, do_start, do_death, do_win;

   // Two-digit BCD increment that saturates at 99.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == 8'h99)
         return v;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Next-state decode and one-cycle game events for the datapath.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d    = state_q;
      do_start   = 1'b0;
      do_death   = 1'b0;
      do_win     = 1'b0;
      pause_done = bus.clk_enable && (pause_cnt == PAUSE_LAST);
      unique case (state_q)
         IDLE, GAME_OVER: begin
            if (bus.start) begin
               state_d  = PLAY;
               do_start = 1'b1;
            end
         end
         PLAY: begin
            // Death wins over a simultaneous goal hit.
            if (bus.death_collision) begin
               do_death = 1'b1;
               state_d  = (lives_q == 3'd1) ? GAME_OVER : DYING;
            end else if (bus.win_collision) begin
               do_win  = 1'b1;
               state_d = LEVEL_UP;
            end
         end
         DYING, LEVEL_UP: begin
            if (pause_done)
               state_d = PLAY;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register plus status flags registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q       <= IDLE;
         round_reset_q <= 1'b1;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         round_reset_q <= (state_d != PLAY);
         game_over_q   <= (state_d == GAME_OVER);
      end
   end

   // Pause counter: cleared when a pause begins, counts game ticks during it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pause_cnt <= '0;
      else if (do_death || do_win)
         pause_cnt <= '0;
      else if ((state_q == DYING || state_q == LEVEL_UP) && bus.clk_enable)
         pause_cnt <= pause_cnt + CNT_W'(1);
   end

   // Lives, level and score bookkeeping driven by the decoded game events.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= 4'd1;
         lives_q <= START_LIVES_L;
         score_q <= 8'h00;
      end else if (do_start) begin
         level_q <= 4'd1;
         lives_q <= START_LIVES_L;
         score_q <= 8'h00;
      end else if (do_death) begin
         lives_q <= lives_q - 3'd1;
      end else if (do_win) begin
         level_q <= (level_q == MAX_LEVEL_L) ? 4'd1 : level_q + 4'd1;
         score_q <= bcd_inc(score_q);
      end
   end

   // Per-lane speed: base minus level, clamped to at least 1 (5-bit signed).
   always_comb begin
      lane_speed_d = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         logic signed [4:0] diff;
         diff = $signed({1'b0, bus.lane_base_speed[4*i +: 4]}) - $signed({1'b0, level_q});
         lane_speed_d[4*i +: 4] = (diff < 5'sd1) ? 4'd1 : diff[3:0];
      end
   end

   // Lane speed register, refreshed every clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lane_speed_q <= '0;
      else
         lane_speed_q <= lane_speed_d;
   end

   assign bus.state       = state_q;
   assign bus.level       = level_q;
   assign bus.lives       = lives_q;
   assign bus.score_bcd   = score_q;
   assign bus.round_reset = round_reset_q;
   assign bus.game_over   = game_over_q;
   assign bus.lane_speed  = lane_speed_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Self-checking bench for frogger_game_fsm: directed game scenarios plus a
// randomized run, all compared each cycle against a behavioural game model.
module tb_frogger_game_fsm;

   localparam int NL   = 11;
   localparam int MAXL = 8;
   localparam int SL   = 3;
   localparam int PT   = 50;

   localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_LEVEL_UP = 3, M_OVER = 4;

   logic clk = 1'b0;
   logic reset;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   frogger_game_fsm_if #(.NUM_LANES(NL)) bus ();

   frogger_game_fsm #(
      .NUM_LANES  (NL),
      .MAX_LEVEL  (MAXL),
      .START_LIVES(SL),
      .PAUSE_TICKS(PT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the game.
   int m_phase;
   int m_level;
   int m_lives;
   int m_wins;
   int m_ticks_left;
   int m_speed[NL];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase      = M_IDLE;
      m_level      = 1;
      m_lives      = SL;
      m_wins       = 0;
      m_ticks_left = 0;
      for (int i = 0; i < NL; i++) m_speed[i] = 0;
   endtask

   task automatic model_step(input bit st, input bit ce, input bit dc, input bit wc,
                             input logic [NL*4-1:0] base);
      for (int i = 0; i < NL; i++) begin
         int s;
         s = int'(base[4*i +: 4]) - m_level;
         m_speed[i] = (s < 1) ? 1 : s;
      end
      case (m_phase)
         M_IDLE, M_OVER: begin
            if (st) begin
               m_phase = M_PLAY;
               m_level = 1;
               m_lives = SL;
               m_wins  = 0;
            end
         end
         M_PLAY: begin
            if (dc) begin
               m_lives      = m_lives - 1;
               m_phase      = (m_lives == 0) ? M_OVER : M_DYING;
               m_ticks_left = PT;
            end else if (wc) begin
               m_level      = (m_level == MAXL) ? 1 : m_level + 1;
               m_wins       = m_wins + 1;
               m_phase      = M_LEVEL_UP;
               m_ticks_left = PT;
            end
         end
         default: begin
            if (ce) begin
               m_ticks_left = m_ticks_left - 1;
               if (m_ticks_left == 0) m_phase = M_PLAY;
            end
         end
      endcase
   endtask

   task automatic compare_all();
      logic [NL*4-1:0] exp_speed;
      int w;
      for (int i = 0; i < NL; i++) exp_speed[4*i +: 4] = 4'(m_speed[i]);
      w = (m_wins > 99) ? 99 : m_wins;
      check("state",       64'(bus.state),       64'(m_phase));
      check("level",       64'(bus.level),       64'(m_level));
      check("lives",       64'(bus.lives),       64'(m_lives));
      check("score_bcd",   64'(bus.score_bcd),   64'((w / 10) * 16 + (w % 10)));
      check("round_reset", 64'(bus.round_reset), 64'(m_phase != M_PLAY));
      check("game_over",   64'(bus.game_over),   64'(m_phase == M_OVER));
      check("lane_speed",  64'(bus.lane_speed),  64'(exp_speed));
   endtask

   // One clock: capture applied inputs, clock, step model, compare.
   task automatic cyc();
      bit st, ce, dc, wc;
      logic [NL*4-1:0] b;
      st = bus.start;
      ce = bus.clk_enable;
      dc = bus.death_collision;
      wc = bus.win_collision;
      b  = bus.lane_base_speed;
      @(posedge clk);
      #1;
      model_step(st, ce, dc, wc, b);
      compare_all();
   endtask

   // Asynchronous reset pulse checked without any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1;
      reset = 1'b0;
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   // Run out a pause with collisions toggling (they must be ignored).
   task automatic pause_out(input bit fast);
      for (int n = 0; n < 2000; n++) begin
         if (m_phase != M_DYING && m_phase != M_LEVEL_UP) break;
         bus.clk_enable      = fast ? 1'b1 : 1'($urandom_range(0, 1));
         bus.death_collision = 1'($urandom_range(0, 1));
         bus.win_collision   = 1'($urandom_range(0, 1));
         cyc();
      end
      bus.death_collision = 1'b0;
      bus.win_collision   = 1'b0;
      bus.clk_enable      = 1'b0;
      check("pause_exit", 64'(bus.state), 64'(m_phase));
   endtask

   task automatic win_once(input bit fast);
      bus.win_collision = 1'b1;
      cyc();
      bus.win_collision = 1'b0;
      pause_out(fast);
   endtask

   task automatic die_once();
      bus.death_collision = 1'b1;
      cyc();
      bus.death_collision = 1'b0;
      pause_out(1'b0);
   endtask

   initial begin
      logic [NL*4-1:0] base;
      reset               = 1'b1;
      bus.clk_enable      = 1'b0;
      bus.start           = 1'b0;
      bus.death_collision = 1'b0;
      bus.win_collision   = 1'b0;
      base = '0;
      for (int i = 0; i < NL; i++) base[4*i +: 4] = 4'($urandom_range(0, 15));
      base[3:0] = 4'd12;
      bus.lane_base_speed = base;
      do_reset();

      // Start a game, lane 0 base 12 -> speed 11.
      cyc();
      start_game();
      cyc();

      // Single win with a full pause.
      win_once(1'b0);
      cyc();

      // Simultaneous death and win at level 4.
      do_reset();
      start_game();
      repeat (3) win_once(1'b1);
      bus.death_collision = 1'b1;
      bus.win_collision   = 1'b1;
      cyc();
      bus.win_collision   = 1'b0;
      bus.death_collision = 1'b0;
      pause_out(1'b0);

      // Three deaths to game over, then restart.
      do_reset();
      start_game();
      repeat (3) die_once();
      repeat (3) cyc();
      start_game();
      cyc();

      // Level wrap, BCD carry and saturation over 100 wins.
      do_reset();
      start_game();
      repeat (100) win_once(1'b1);

      // Base 3 at level 5, then reset in the middle of a level-up pause.
      do_reset();
      base[3:0] = 4'd3;
      bus.lane_base_speed = base;
      start_game();
      repeat (4) win_once(1'b1);
      repeat (2) cyc();
      bus.win_collision = 1'b1;
      cyc();
      bus.win_collision = 1'b0;
      bus.clk_enable    = 1'b1;
      repeat (10) cyc();
      do_reset();
      cyc();

      // Randomized play.
      for (int n = 0; n < 3000; n++) begin
         bus.start           = ($urandom_range(0, 7) == 0);
         bus.clk_enable      = 1'($urandom_range(0, 1));
         bus.death_collision = ($urandom_range(0, 19) == 0);
         bus.win_collision   = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0) begin
            for (int i = 0; i < NL; i++) base[4*i +: 4] = 4'($urandom_range(0, 15));
            bus.lane_base_speed = base;
         end
         if ($urandom_range(0, 499) == 0)
            do_reset();
         else
            cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
